// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

    localparam int unsigned UART_PARITY_EVEN   = 0;
    localparam int unsigned UART_PARITY_ODD    = 1;

    localparam int unsigned UART_DATA_BITS_MIN = 5;
    localparam int unsigned UART_DATA_BITS_MAX = 9;

endpackage

// File: rtl/uart_tx_fifo_param_fifo.sv
// Synchronous FIFO with one-cycle push/pop, registered count/flags and overflow pulse.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata_c,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_overflow;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;

    assign w_push = i_push & ~r_full;
    assign w_pop  = i_pop & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // A write while full is dropped and flagged even if a pop frees a slot this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == CW'(DEPTH));
            r_empty    <= (w_count_nxt == '0);
            r_overflow <= i_push & r_full;
        end
    end

    assign o_rdata_c  = r_mem[r_rd_ptr];
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Buffered UART transmitter: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stops.
// Parity is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                        clk_50m,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        din,
    input  logic                        wr_en,
    input  logic                        clken,
    output logic                        tx,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam int unsigned STOP_W = 2;

    uart_tx_state_t         r_state;
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_done;
    logic [DATA_BITS-1:0]   r_shift;
    logic [BIT_W-1:0]       r_bitpos;
    logic [STOP_W-1:0]      r_stop_cnt;

    uart_tx_state_t         w_state_nxt;
    logic                   w_tx_nxt;
    logic                   w_done_nxt;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic [BIT_W-1:0]       w_bitpos_nxt;
    logic [STOP_W-1:0]      w_stop_nxt;
    logic                   w_pop;
    logic                   w_fifo_empty;
    logic [DATA_BITS-1:0]   w_fifo_rdata;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk_50m),
        .rst        (rst),
        .i_push     (wr_en),
        .i_wdata    (din),
        .i_pop      (w_pop),
        .o_rdata_c  (w_fifo_rdata),
        .o_full     (fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (fifo_count),
        .o_overflow (overflow)
    );

`ifdef UART_TX_PARITY_EN
    logic w_parity;
    assign w_parity = (^r_shift) ^ (PARITY_ODD != UART_PARITY_EVEN);
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = (PARITY_ODD != UART_PARITY_EVEN);
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_tx_nxt     = r_tx;
        w_done_nxt   = 1'b0;
        w_shift_nxt  = r_shift;
        w_bitpos_nxt = r_bitpos;
        w_stop_nxt   = r_stop_cnt;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_fifo_rdata;
                    w_bitpos_nxt = '0;
                    w_state_nxt  = ST_START;
                end
            end
            ST_START: begin
                if (clken) begin
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (clken) begin
                    w_tx_nxt     = r_shift[r_bitpos];
                    w_bitpos_nxt = r_bitpos + BIT_W'(1);
                    if (r_bitpos == BIT_W'(DATA_BITS - 1)) begin
                        w_stop_nxt  = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (clken) begin
                    w_tx_nxt    = w_parity;
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            // The tick ending the last stop bit doubles as the next frame's start bit.
            ST_STOP: begin
                if (clken) begin
                    w_tx_nxt = 1'b1;
                    if (r_stop_cnt == STOP_W'(STOP_BITS)) begin
                        w_done_nxt = 1'b1;
                        w_stop_nxt = '0;
                        if (!w_fifo_empty) begin
                            w_pop        = 1'b1;
                            w_shift_nxt  = w_fifo_rdata;
                            w_bitpos_nxt = '0;
                            w_tx_nxt     = 1'b0;
                            w_state_nxt  = ST_DATA;
                        end else begin
                            w_state_nxt  = ST_IDLE;
                        end
                    end else begin
                        w_stop_nxt = r_stop_cnt + STOP_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_shift    <= '0;
            r_bitpos   <= '0;
            r_stop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_done_nxt;
            r_shift    <= w_shift_nxt;
            r_bitpos   <= w_bitpos_nxt;
            r_stop_cnt <= w_stop_nxt;
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench: an 8N1 depth-4 instance (A) and a 7-bit, 2-stop, odd-parity instance (B).
module tb_uart_tx_fifo_param;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Tick index that ends the frame: start + data + parity + stops + 1.
    localparam int A_TOT = 2 + 8 + PB + 1;
    localparam int B_TOT = 2 + 7 + PB + 2;

    logic       clk_50m = 1'b0;
    logic       rst;
    logic       clken;
    logic [7:0] a_din;
    logic       a_wr, a_tx, a_busy, a_done, a_full, a_ovf;
    logic [2:0] a_count;
    logic [6:0] b_din;
    logic       b_wr, b_tx, b_busy, b_done, b_full, b_ovf;
    logic [2:0] b_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_50m = ~clk_50m;

    uart_tx_fifo_param #(
        .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) u_dut_a (
        .clk_50m(clk_50m), .rst(rst), .din(a_din), .wr_en(a_wr), .clken(clken),
        .tx(a_tx), .tx_busy(a_busy), .tx_done(a_done), .fifo_full(a_full),
        .fifo_count(a_count), .overflow(a_ovf)
    );

    uart_tx_fifo_param #(
        .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(1)
    ) u_dut_b (
        .clk_50m(clk_50m), .rst(rst), .din(b_din), .wr_en(b_wr), .clken(clken),
        .tx(b_tx), .tx_busy(b_busy), .tx_done(b_done), .fifo_full(b_full),
        .fifo_count(b_count), .overflow(b_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ten-cycle tick spacing; returns on the falling edge right after the tick edge.
    task automatic tick();
        repeat (9) @(negedge clk_50m);
        clken = 1'b1;
        @(negedge clk_50m);
        clken = 1'b0;
    endtask

    task automatic push_a(input logic [7:0] d);
        @(negedge clk_50m);
        a_din = d;
        a_wr  = 1'b1;
        @(negedge clk_50m);
        a_wr  = 1'b0;
    endtask

    task automatic check_frame(input bit sel, input logic [8:0] data, input int nd, input int ns,
                               input bit podd, input int first_k, input int last_k, input bit more);
        int   total;
        logic exp_tx;
        logic par;
        total = 2 + nd + PB + ns;
        par   = (^data) ^ podd;
        for (int k = first_k; k <= last_k; k++) begin
            tick();
            if (k == 1)                       exp_tx = 1'b0;
            else if (k <= 1 + nd)             exp_tx = data[k-2];
            else if (PB == 1 && k == 2 + nd)  exp_tx = par;
            else if (k < total)               exp_tx = 1'b1;
            else                              exp_tx = more ? 1'b0 : 1'b1;
            chk($sformatf("%s d=%0h tx k=%0d", sel ? "B" : "A", data, k), sel ? b_tx : a_tx, exp_tx);
            chk($sformatf("%s d=%0h done k=%0d", sel ? "B" : "A", data, k),
                sel ? b_done : a_done, (k == total));
        end
        if (last_k == total)
            chk($sformatf("%s d=%0h busy_after", sel ? "B" : "A", data), sel ? b_busy : a_busy, more);
    endtask

    initial begin
        rst = 1'b0; clken = 1'b0;
        a_wr = 1'b0; a_din = '0; b_wr = 1'b0; b_din = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk_50m);
        chk("rst tx",    a_tx,    1);
        chk("rst busy",  a_busy,  0);
        chk("rst done",  a_done,  0);
        chk("rst full",  a_full,  0);
        chk("rst count", a_count, 0);
        chk("rst ovf",   a_ovf,   0);
        chk("rst b_tx",  b_tx,    1);
        rst = 1'b0;

        // Single 0xA5 frame and push-to-pop latency
        push_a(8'hA5);
        chk("lat count+1", a_count, 1);
        chk("lat busy+1",  a_busy,  0);
        @(negedge clk_50m);
        chk("lat busy+2",  a_busy,  1);
        chk("lat count+2", a_count, 0);
        chk("lat tx+2",    a_tx,    1);
        check_frame(0, 9'h0A5, 8, 1, 0, 1, A_TOT, 0);

        // Tick while idle changes nothing
        tick();
        chk("idle tx",   a_tx,   1);
        chk("idle done", a_done, 0);
        chk("idle busy", a_busy, 0);

        // 0x07: parity bit 1 when even parity is compiled in
        push_a(8'h07);
        check_frame(0, 9'h007, 8, 1, 0, 1, A_TOT, 0);

        // Three back-to-back frames
        @(negedge clk_50m); a_din = 8'h11; a_wr = 1'b1;
        @(negedge clk_50m); a_din = 8'h22;
        @(negedge clk_50m); a_din = 8'h33;
        @(negedge clk_50m); a_wr = 1'b0;
        chk("b2b count", a_count, 2);
        check_frame(0, 9'h011, 8, 1, 0, 1, A_TOT, 1);
        check_frame(0, 9'h022, 8, 1, 0, 2, A_TOT, 1);
        check_frame(0, 9'h033, 8, 1, 0, 2, A_TOT, 0);

        // Fill while a frame waits for its start tick, then overflow
        push_a(8'hC3);
        @(negedge clk_50m);
        chk("ovf primer busy",  a_busy,  1);
        chk("ovf primer count", a_count, 0);
        for (int i = 0; i < 5; i++) begin
            a_din = 8'(1 << i);
            a_wr  = 1'b1;
            @(negedge clk_50m);
            chk($sformatf("fill count %0d", i), a_count, (i < 4) ? i + 1 : 4);
            chk($sformatf("fill full %0d", i),  a_full,  (i >= 3));
            chk($sformatf("fill ovf %0d", i),   a_ovf,   (i == 4));
        end
        a_wr = 1'b0;
        @(negedge clk_50m);
        chk("ovf pulse width", a_ovf,   0);
        chk("ovf count hold",  a_count, 4);
        chk("ovf full hold",   a_full,  1);
        check_frame(0, 9'h0C3, 8, 1, 0, 1, A_TOT - 1, 1);
        // Write while full on the tick that pops: still dropped and flagged
        repeat (9) @(negedge clk_50m);
        clken = 1'b1; a_wr = 1'b1; a_din = 8'hEE;
        @(negedge clk_50m);
        clken = 1'b0; a_wr = 1'b0;
        chk("popwr done",  a_done,  1);
        chk("popwr tx",    a_tx,    0);
        chk("popwr ovf",   a_ovf,   1);
        chk("popwr count", a_count, 3);
        chk("popwr full",  a_full,  0);
        check_frame(0, 9'h001, 8, 1, 0, 2, A_TOT, 1);
        check_frame(0, 9'h002, 8, 1, 0, 2, A_TOT, 1);
        check_frame(0, 9'h004, 8, 1, 0, 2, A_TOT, 1);
        check_frame(0, 9'h008, 8, 1, 0, 2, A_TOT, 0);
        chk("drain count", a_count, 0);

        // 7 data bits, 2 stop bits, odd parity when compiled in
        @(negedge clk_50m); b_din = 7'h55; b_wr = 1'b1;
        @(negedge clk_50m); b_wr = 1'b0;
        check_frame(1, 9'h055, 7, 2, 1, 1, B_TOT, 0);
        chk("B count end", b_count, 0);

        // Reset during data bit 3 (a 0) with a word still queued
        @(negedge clk_50m); a_din = 8'h52; a_wr = 1'b1;
        @(negedge clk_50m); a_din = 8'h3C;
        @(negedge clk_50m); a_wr = 1'b0;
        check_frame(0, 9'h052, 8, 1, 0, 1, 5, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid rst tx",    a_tx,    1);
        chk("mid rst busy",  a_busy,  0);
        chk("mid rst count", a_count, 0);
        chk("mid rst full",  a_full,  0);
        @(negedge clk_50m);
        rst = 1'b0;
        for (int i = 0; i < A_TOT; i++) begin
            tick();
            chk($sformatf("post rst done %0d", i), a_done, 0);
            chk($sformatf("post rst tx %0d", i),   a_tx,   1);
        end
        chk("post rst busy",  a_busy,  0);
        chk("post rst count", a_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
